// File: rtl/fir_ctrl_pkg.sv
// rtl/fir_ctrl_pkg.sv - shared state encoding and default geometry for the FIR stream controller
package fir_ctrl_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int TAPS_DEF    = 3;
  localparam int LAT_DEF     = 1;
  localparam int FRAME_LEN_W = 16;
  // One bit wider than frame_len so a full frame plus its flush tail never wraps.
  localparam int CNT_W       = FRAME_LEN_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_FLUSH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/fir_stream_ctrl_if.sv
// rtl/fir_stream_ctrl_if.sv - control, input stream, FIR-side and output signals of fir_stream_ctrl
interface fir_stream_ctrl_if #(
  parameter int DATA_W = fir_ctrl_pkg::DATA_W_DEF
);
  import fir_ctrl_pkg::*;

  logic                   start;
  logic [FRAME_LEN_W-1:0] frame_len;
  logic                   in_valid;
  logic [DATA_W-1:0]      in_data;
  logic                   in_ready;
  logic                   fir_en;
  logic [DATA_W-1:0]      fir_x;
  logic [DATA_W-1:0]      fir_y;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic                   busy;
  logic                   done;

  modport master (
    output start, frame_len, in_valid, in_data, fir_y,
    input  in_ready, fir_en, fir_x, out_valid, out_data, busy, done
  );

  modport slave (
    input  start, frame_len, in_valid, in_data, fir_y,
    output in_ready, fir_en, fir_x, out_valid, out_data, busy, done
  );

endinterface

// File: rtl/fir_valid_pipe.sv
// rtl/fir_valid_pipe.sv - valid delay line matching the external FIR datapath latency
module fir_valid_pipe
  import fir_ctrl_pkg::*;
#(
  parameter int LAT = LAT_DEF
) (
  input  logic clk,
  input  logic rstN,
  input  logic i_en,
  output logic o_valid
);

  logic [LAT-1:0] r_pipe;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_en;
      for (int i = 1; i < LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_valid = r_pipe[LAT-1];

endmodule

// File: rtl/fir_stream_ctrl.sv
// rtl/fir_stream_ctrl.sv - frame sequencer feeding an external FIR: run, zero-flush, drain, done
module fir_stream_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAPS   = TAPS_DEF,
  parameter int LAT    = LAT_DEF
) (
  input logic              clk,
  input logic              rstN,
  fir_stream_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] FLUSH_LEN = CNT_W'(TAPS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_in_cnt;
  logic [CNT_W-1:0]   r_out_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;

  logic               w_pipe_valid;
  logic               w_in_ready;
  logic               w_fir_en;
  logic [DATA_W-1:0]  w_fir_x;
  logic               w_hs;
  logic [CNT_W-1:0]   w_in_cnt_inc;
  logic [CNT_W-1:0]   w_total;
  logic [CNT_W-1:0]   w_out_seen;

  assign w_hs         = bus.in_valid && (r_state == S_RUN);
  assign w_in_cnt_inc = r_in_cnt + CNT_ONE;
  assign w_total      = r_len + FLUSH_LEN;
  // Counting the output visible this cycle lets done follow the last output by one clock.
  assign w_out_seen   = r_out_cnt + CNT_W'(r_out_valid);

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_fir_en    = 1'b0;
    w_fir_x     = '0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = (bus.frame_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_fir_en = 1'b1;
          w_fir_x  = bus.in_data;
          if (w_in_cnt_inc == r_len) begin
            w_state_nxt = (TAPS > 1) ? S_FLUSH : S_DRAIN;
          end
        end
      end
      S_FLUSH: begin
        w_fir_en = 1'b1;
        if (r_flush_cnt == FLUSH_LEN - CNT_ONE) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_out_seen == w_total) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_flush_cnt <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_pipe_valid;
      if (w_pipe_valid) begin
        r_out_data <= bus.fir_y;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_len       <= {1'b0, bus.frame_len};
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_flush_cnt <= '0;
          end
        end
        S_RUN: begin
          if (w_hs) begin
            r_in_cnt <= w_in_cnt_inc;
          end
        end
        S_FLUSH: begin
          r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
        default: begin
        end
      endcase
      if (r_state != S_IDLE && r_out_valid) begin
        r_out_cnt <= r_out_cnt + CNT_ONE;
      end
    end
  end

  fir_valid_pipe #(
    .LAT (LAT)
  ) u_valid_pipe (
    .clk     (clk),
    .rstN    (rstN),
    .i_en    (w_fir_en),
    .o_valid (w_pipe_valid)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.fir_en    = w_fir_en;
  assign bus.fir_x     = w_fir_x;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// tb/tb_fir_stream_ctrl.sv - randomized self-checking bench for fir_stream_ctrl with a 3-tap FIR stand-in
module tb_fir_stream_ctrl;
  import fir_ctrl_pkg::*;

  localparam int DW = 16;
  localparam int NT = 3;
  localparam int NL = 1;
  localparam int COEF [NT] = '{1, 2, 3};

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  fir_stream_ctrl_if #(.DATA_W(DW)) bus ();

  fir_stream_ctrl #(.DATA_W(DW), .TAPS(NT), .LAT(NL)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  // One-clock FIR stand-in: y = x + 2*x[-1] + 3*x[-2], advancing only on fir_en.
  logic [DW-1:0] h0, h1;
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      h0 <= '0;
      h1 <= '0;
      bus.fir_y <= '0;
    end else if (bus.fir_en) begin
      h0 <= bus.fir_x;
      h1 <= h0;
      bus.fir_y <= bus.fir_x + DW'(2) * h0 + DW'(3) * h1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] out_q[$], fx_q[$], acc_q[$], exp_q[$], fix_q[$];
  int out_cyc[$], en_cyc[$], hs_cyc[$];
  int done_n, done_cyc, busy_n, st_cyc;
  int n_vec = 0;
  int n_err = 0;

  always @(negedge clk) begin
    if (rstN) begin
      if (bus.out_valid) begin out_q.push_back(bus.out_data); out_cyc.push_back(cyc); end
      if (bus.fir_en) begin fx_q.push_back(bus.fir_x); en_cyc.push_back(cyc); end
      if (bus.in_valid && bus.in_ready) hs_cyc.push_back(cyc);
      if (bus.done) begin done_n++; done_cyc = cyc; end
      if (bus.busy) busy_n++;
    end
  end

  task automatic clear_mon();
    out_q.delete(); out_cyc.delete(); fx_q.delete(); en_cyc.delete();
    hs_cyc.delete(); fix_q.delete();
    done_n = 0; done_cyc = -1; busy_n = 0;
  endtask

  // Frame output = accepted samples followed by TAPS-1 zeros, convolved from zero history.
  task automatic build_exp();
    int n;
    int s;
    n = acc_q.size();
    exp_q.delete();
    for (int i = 0; i < n + NT - 1; i++) begin
      s = 0;
      for (int k = 0; k < NT; k++)
        if (i - k >= 0 && i - k < n) s += COEF[k] * int'($signed(acc_q[i-k]));
      exp_q.push_back(DW'(s));
    end
  endtask

  task automatic send_start(input int len);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.frame_len = 16'(len); st_cyc = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // mode 0: always valid, 1: alternating starting high, 2: random
  task automatic feed(input int len, input int mode, input int stop_after, input bit poke);
    int n = 0;
    int t = 0;
    bit v;
    logic [DW-1:0] d;
    acc_q.delete();
    while (n < len && n != stop_after && t < 200000) begin
      case (mode)
        0: v = 1'b1;
        1: v = (t % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      d = (n < fix_q.size()) ? fix_q[n] : DW'($urandom);
      bus.in_valid = v; bus.in_data = d;
      if (poke && t == 1) begin bus.start = 1'b1; bus.frame_len = 16'd2; end
      else bus.start = 1'b0;
      @(negedge clk);
      if (v && bus.in_ready) begin acc_q.push_back(d); n++; end
      @(posedge clk); #1;
      t++;
    end
    bus.in_valid = 1'b0; bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (done_n == 0 && t < budget) begin @(posedge clk); #1; t++; end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    bus.start = 1'b0; bus.frame_len = '0; bus.in_valid = 1'b1; bus.in_data = 16'h1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({bus.out_valid, bus.out_data} !== '0) begin
      n_err++; $display("FAIL reset_out got %b/%h want 0/0000", bus.out_valid, bus.out_data);
    end
    n_vec++;
    if ({bus.done, bus.busy, bus.in_ready} !== 3'b000) begin
      n_err++; $display("FAIL reset_ctrl done/busy/ready got %b%b%b want 000", bus.done, bus.busy, bus.in_ready);
    end
    n_vec++;
    if ({bus.fir_en, bus.fir_x} !== '0) begin
      n_err++; $display("FAIL reset_fir got %b/%h want 0/0000", bus.fir_en, bus.fir_x);
    end
    @(posedge clk); #1;
    rstN = 1'b1;
    clear_mon();
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (fx_q.size() != 0 || hs_cyc.size() != 0 || busy_n != 0) begin
      n_err++; $display("FAIL idle_ignores_valid got en=%0d hs=%0d busy=%0d want 0/0/0", fx_q.size(), hs_cyc.size(), busy_n);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_basic_frame();
    clear_mon();
    fix_q = '{16'd100, 16'd200, 16'd300, 16'd400};
    send_start(4); feed(4, 0, -1, 1'b0); build_exp(); wait_done(50);
    n_vec++;
    if (hs_cyc.size() != 4) begin n_err++; $display("FAIL basic_handshakes got %0d want 4", hs_cyc.size()); end
    n_vec++;
    if (fx_q.size() != 6 || fx_q[4] !== '0 || fx_q[5] !== '0) begin
      n_err++; $display("FAIL basic_flush got n=%0d want 6 with two zero tail samples", fx_q.size());
    end
    n_vec++;
    if (out_q.size() != 6 || out_cyc[0] != hs_cyc[0] + NL + 1) begin
      n_err++; $display("FAIL basic_out got n=%0d first_lat=%0d want 6/%0d", out_q.size(), out_cyc[0] - hs_cyc[0], NL + 1);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL basic_data[%0d] got %0d want %0d", i, (i < out_q.size()) ? out_q[i] : 'x, exp_q[i]);
      end
    end
    n_vec++;
    if (done_n != 1 || done_cyc != out_cyc[out_cyc.size()-1] + 1) begin
      n_err++; $display("FAIL basic_done got n=%0d at +%0d want 1 at +1", done_n, done_cyc - out_cyc[out_cyc.size()-1]);
    end
  endtask

  task automatic test_gapped_input();
    clear_mon();
    send_start(3); feed(3, 1, -1, 1'b0); build_exp(); wait_done(50);
    n_vec++;
    if (en_cyc.size() != 5 || hs_cyc.size() != 3) begin
      n_err++; $display("FAIL gap_counts got en=%0d hs=%0d want 5/3", en_cyc.size(), hs_cyc.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (en_cyc[i] != hs_cyc[i] || fx_q[i] !== acc_q[i]) begin
        n_err++; $display("FAIL gap_en[%0d] got cyc %0d x %h want cyc %0d x %h", i, en_cyc[i], fx_q[i], hs_cyc[i], acc_q[i]);
      end
    end
    n_vec++;
    if (out_q.size() != 5) begin n_err++; $display("FAIL gap_out_count got %0d want 5", out_q.size()); end
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      n_vec++;
      if (out_cyc[i] != en_cyc[i] + NL + 1 || out_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL gap_out[%0d] got lat %0d data %0d want lat %0d data %0d", i, out_cyc[i] - en_cyc[i], out_q[i], NL + 1, exp_q[i]);
      end
    end
    n_vec++;
    if (done_n != 1) begin n_err++; $display("FAIL gap_done got %0d want 1", done_n); end
  endtask

  task automatic test_zero_len();
    clear_mon();
    send_start(0); wait_done(10);
    n_vec++;
    if (done_n != 1 || done_cyc != st_cyc + 1) begin
      n_err++; $display("FAIL zero_done got n=%0d at +%0d want 1 at +1", done_n, done_cyc - st_cyc);
    end
    n_vec++;
    if (busy_n != 1 || out_q.size() != 0 || fx_q.size() != 0) begin
      n_err++; $display("FAIL zero_activity got busy=%0d out=%0d en=%0d want 1/0/0", busy_n, out_q.size(), fx_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    clear_mon();
    send_start(5); feed(5, 0, -1, 1'b1); build_exp(); wait_done(50);
    n_vec++;
    if (hs_cyc.size() != 5 || out_q.size() != 7 || done_n != 1) begin
      n_err++; $display("FAIL restart_counts got hs=%0d out=%0d done=%0d want 5/7/1", hs_cyc.size(), out_q.size(), done_n);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL restart_data[%0d] got %0d want %0d", i, (i < out_q.size()) ? out_q[i] : 'x, exp_q[i]);
      end
    end
    n_vec++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL restart_idle busy got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    send_start(4); feed(4, 0, 2, 1'b0);
    bus.in_valid = 1'b1;
    #2;
    rstN = 1'b0;
    #1;
    n_vec++;
    if ({bus.out_valid, bus.out_data, bus.done, bus.busy, bus.in_ready, bus.fir_en, bus.fir_x} !== '0) begin
      n_err++; $display("FAIL midreset_outputs got v=%b d=%h done=%b busy=%b rdy=%b en=%b x=%h want all 0",
        bus.out_valid, bus.out_data, bus.done, bus.busy, bus.in_ready, bus.fir_en, bus.fir_x);
    end
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;
    n_vec++;
    if (done_n != 0) begin n_err++; $display("FAIL midreset_no_done got %0d want 0", done_n); end
    clear_mon();
    send_start(2); feed(2, 0, -1, 1'b0); build_exp(); wait_done(50);
    n_vec++;
    if (out_q.size() != 4 || done_n != 1) begin
      n_err++; $display("FAIL midreset_refrm got out=%0d done=%0d want 4/1", out_q.size(), done_n);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL midreset_data[%0d] got %0d want %0d", i, (i < out_q.size()) ? out_q[i] : 'x, exp_q[i]);
      end
    end
  endtask

  task automatic test_random_frames();
    int len;
    for (int f = 0; f < 4; f++) begin
      clear_mon();
      len = $urandom_range(1, 20);
      send_start(len); feed(len, 2, -1, 1'b0); build_exp(); wait_done(100);
      n_vec++;
      if (out_q.size() != len + NT - 1 || done_n != 1 || fx_q.size() != len + NT - 1) begin
        n_err++; $display("FAIL rand%0d_counts got out=%0d en=%0d done=%0d want %0d/%0d/1", f, out_q.size(), fx_q.size(), done_n, len + NT - 1, len + NT - 1);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        n_vec++;
        if (i >= out_q.size() || out_q[i] !== exp_q[i] || out_cyc[i] != en_cyc[i] + NL + 1) begin
          n_err++; $display("FAIL rand%0d_out[%0d] got %0d want %0d", f, i, (i < out_q.size()) ? out_q[i] : 'x, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_max_frame();
    int bad = 0;
    clear_mon();
    send_start(65535); feed(65535, 0, -1, 1'b0); build_exp(); wait_done(200);
    n_vec++;
    if (out_q.size() != 65537 || done_n != 1) begin
      n_err++; $display("FAIL max_counts got out=%0d done=%0d want 65537/1", out_q.size(), done_n);
    end
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL max_data got %0d bad samples want 0", bad); end
  endtask

  initial begin
    bus.start = 1'b0; bus.frame_len = '0; bus.in_valid = 1'b0; bus.in_data = '0;
    test_reset();
    test_basic_frame();
    test_gapped_input();
    test_zero_len();
    test_start_while_busy();
    test_reset_mid_frame();
    test_random_frames();
    test_max_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_stream_ctrl.md
FIR_STREAM_CTRL -- requirements
Module: fir_stream_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16: sample width, signed two's complement.
REQ-002 SHALL have parameter TAPS, default 3: FIR tap count; sets flush length TAPS-1.
REQ-003 SHALL have parameter LAT, default 1: FIR datapath latency in clocks, from enabled input to valid y.
REQ-004 SHALL have one clock, and reset SHALL be asynchronous and active-low; ports are clk and rstN.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rstN  in  1  async active-low reset.
REQ-007 start  in  1  one-cycle frame start request.
REQ-008 frame_len  in  16  samples in frame, unsigned, sampled on accepted start.
REQ-009 in_valid  in  1  input sample valid.
REQ-010 in_data  in  DATA_W  input sample.
REQ-011 in_ready  out  1  controller accepts sample this cycle.
REQ-012 fir_en  out  1  FIR shift enable, combinational.
REQ-013 fir_x  out  DATA_W  FIR input sample, combinational.
REQ-014 fir_y  in  DATA_W  FIR output sample.
REQ-015 out_valid  out  1  out_data valid, registered.
REQ-016 out_data  out  DATA_W  filtered sample, registered.
REQ-017 busy  out  1  high in any state except IDLE.
REQ-018 done  out  1  one-cycle pulse after last output of frame.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, FLUSH, DRAIN, DONE.
REQ-020 IDLE: start=1 with frame_len>0 -> RUN, latch frame_len, clear in_cnt and out_cnt; start=1 with frame_len=0 -> DONE; start while busy SHALL be ignored.
REQ-021 RUN: in_ready=1; handshake = in_valid&&in_ready drives fir_en=1, fir_x=in_data; with no handshake, fir_en=0 and fir_x=0.
REQ-022 RUN: in_cnt increments per handshake; the handshake making in_cnt=frame_len -> FLUSH next cycle.
REQ-023 FLUSH: in_ready=0, fir_en=1, fir_x=0 for exactly TAPS-1 consecutive cycles, then -> DRAIN; TAPS=1 SHALL skip FLUSH.
REQ-024 Valid delay line: fir_en shifts through LAT stages every clock; stage LAT output registers out_valid<=1 and out_data<=fir_y next edge; total latency handshake -> out_valid = LAT+1 cycles.
REQ-025 out_data SHALL hold its last value when out_valid=0; no backpressure on output.
REQ-026 out_cnt increments per out_valid; DRAIN waits until out_cnt = frame_len+TAPS-1, then -> DONE.
REQ-027 DONE: done=1 for one cycle, -> IDLE; start in DONE cycle ignored.
REQ-028 Counters SHALL be 17 bits so frame_len=65535 plus flush does not wrap.
REQ-029 in_ready SHALL be 0 in IDLE, FLUSH, DRAIN, DONE; in_valid there SHALL have no effect.
REQ-030 No arithmetic on sample data; fir_y passed through bit-exact.

Reset
REQ-031 rstN low SHALL asynchronously force state IDLE, counters 0, delay line 0, out_valid=0, out_data=0, done=0, busy=0, in_ready=0, fir_en=0, fir_x=0.
REQ-032 Reset mid-frame SHALL abandon the frame with no done pulse; first start after release begins a fresh frame.

Structure
REQ-033 Shared package fir_ctrl_pkg SHALL hold the state enum and DATA_W/TAPS/LAT defaults.
REQ-034 Valid delay line SHALL be sub-module fir_valid_pipe (depth LAT, async active-low reset).

Verification
REQ-035 frame_len=4, in_valid held high, samples 100,200,300,400 -> 4 RUN handshakes, 2 FLUSH cycles with fir_x=0, exactly 6 out_valid pulses, first 2 cycles after first handshake, done one cycle after 6th.
REQ-036 frame_len=3, in_valid toggling 1,0,1,0,1 -> fir_en high only on 3 handshake cycles, out_valid gaps mirror input gaps, 5 outputs total.
REQ-037 frame_len=0 start -> done pulse next cycle, busy high one cycle, zero out_valid.
REQ-038 start pulsed again during RUN of frame_len=5 -> ignored, frame completes with 7 outputs, one done.
REQ-039 rstN low after 2 of 4 samples -> all outputs 0 immediately, no done; new start frame_len=2 -> 4 outputs, done.
REQ-040 frame_len=65535 continuous input -> 65537 outputs, single done, no counter wrap.
